register_file_controller: RTL and testbench

Sequential execute/write-back controller that sits directly upstream of the 4×32-bit register file. It accepts one instruction at a time over a valid/ready handshake and drives the register file's two read-address ports. It captures the operands, computes a 32-bit result (single-cycle ALU ops or an iterative 32-cycle multiply), and produces the register file's write_register/write_data/write_enable with a guarded setup/strobe/hold sequence.

---
 rtl/register_file_controller_if.sv | 47 ++++
 rtl/register_file_controller.sv | 164 ++++++++++++++++
 tb/tb_register_file_controller.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/register_file_controller_if.sv
// register_file_controller_if
//   Bundles the instruction handshake and the 4x32 register-file port signals
//   between the execute/write-back controller and its environment.
//   master : the controller (accepts instructions, drives register-file ports)
//   slave  : the instruction source / register file side
//   Signals:
//     instruction_valid/ready, opcode[2:0], destination_register[1:0],
//     source_register_0/1[1:0], immediate[15:0]        instruction handshake
//     read_register_port_0/1[1:0], read_data_port_0/1   register-file reads
//     write_register[1:0], write_data[31:0], write_enable register-file write
//     zero_flag, retired_count[15:0]                    status
interface register_file_controller_if;
    logic        instruction_valid;
    logic        instruction_ready;
    logic [2:0]  opcode;
    logic [1:0]  destination_register;
    logic [1:0]  source_register_0;
    logic [1:0]  source_register_1;
    logic [15:0] immediate;
    logic [1:0]  read_register_port_0;
    logic [1:0]  read_register_port_1;
    logic [31:0] read_data_port_0;
    logic [31:0] read_data_port_1;
    logic [1:0]  write_register;
    logic [31:0] write_data;
    logic        write_enable;
    logic        zero_flag;
    logic [15:0] retired_count;

    modport master (
        input  instruction_valid, opcode, destination_register,
               source_register_0, source_register_1, immediate,
               read_data_port_0, read_data_port_1,
        output instruction_ready, read_register_port_0, read_register_port_1,
               write_register, write_data, write_enable,
               zero_flag, retired_count
    );

    modport slave (
        output instruction_valid, opcode, destination_register,
               source_register_0, source_register_1, immediate,
               read_data_port_0, read_data_port_1,
        input  instruction_ready, read_register_port_0, read_register_port_1,
               write_register, write_data, write_enable,
               zero_flag, retired_count
    );
endinterface

// File: rtl/register_file_controller.sv
// register_file_controller
//   Sequential execute/write-back controller in front of a 4x32 register file.
//   One instruction at a time: accept -> read operands -> execute (1 cycle, or
//   32-cycle shift-add MUL) -> setup/strobe/hold write sequence -> idle.
//   Ports:
//     clk_i  rising-edge clock
//     rst_i  asynchronous active-high reset
//     bus    register_file_controller_if.master (handshake + register-file ports)
module register_file_controller (
    input  logic                        clk_i,
    input  logic                        rst_i,
    register_file_controller_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPERAND,
        S_EXECUTE,
        S_SETUP,
        S_WRITE,
        S_HOLD
    } state_e;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_MUL = 3'b110,
        OP_LDI = 3'b111
    } opcode_e;

    state_e      state_q, state_d;
    opcode_e     opcode_q;
    logic [1:0]  dest_q;
    logic [1:0]  src0_q;
    logic [1:0]  src1_q;
    logic [15:0] imm_q;
    // Operand A/B; during MUL they double as shifting multiplicand/multiplier.
    logic [31:0] op_a_q;
    logic [31:0] op_b_q;
    logic [31:0] acc_q;
    logic [4:0]  mul_cnt_q;
    logic [1:0]  wr_reg_q;
    logic [31:0] wr_data_q;
    logic        wr_en_q;
    logic        zero_q;
    logic [15:0] retired_q;

    logic        accept;
    logic        exec_done;
    logic [31:0] alu_result;
    logic [31:0] mul_acc_next;

    assign bus.instruction_ready    = (state_q == S_IDLE) & ~rst_i;
    assign accept                   = bus.instruction_valid & bus.instruction_ready;
    assign bus.read_register_port_0 = src0_q;
    assign bus.read_register_port_1 = src1_q;
    assign bus.write_register       = wr_reg_q;
    assign bus.write_data           = wr_data_q;
    assign bus.write_enable         = wr_en_q;
    assign bus.zero_flag            = zero_q;
    assign bus.retired_count        = retired_q;

    assign mul_acc_next = acc_q + (op_b_q[0] ? op_a_q : '0);
    assign exec_done    = (opcode_q != OP_MUL) || (mul_cnt_q == 5'd31);

    always_comb begin
        alu_result = '0;
        case (opcode_q)
            OP_ADD:  alu_result = op_a_q + op_b_q;
            OP_SUB:  alu_result = op_a_q - op_b_q;
            OP_AND:  alu_result = op_a_q & op_b_q;
            OP_OR:   alu_result = op_a_q | op_b_q;
            OP_XOR:  alu_result = op_a_q ^ op_b_q;
            OP_SLT:  alu_result = {31'd0, ($signed(op_a_q) < $signed(op_b_q))};
            OP_LDI:  alu_result = {16'd0, imm_q};
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (accept) state_d = S_OPERAND;
            S_OPERAND: state_d = S_EXECUTE;
            S_EXECUTE: if (exec_done) state_d = S_SETUP;
            S_SETUP:   state_d = S_WRITE;
            S_WRITE:   state_d = S_HOLD;
            S_HOLD:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            wr_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            // Registered strobe: high exactly while the state register holds WRITE.
            wr_en_q <= (state_d == S_WRITE);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            opcode_q  <= OP_ADD;
            dest_q    <= '0;
            src0_q    <= '0;
            src1_q    <= '0;
            imm_q     <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            acc_q     <= '0;
            mul_cnt_q <= '0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
            zero_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        opcode_q <= opcode_e'(bus.opcode);
                        dest_q   <= bus.destination_register;
                        src0_q   <= bus.source_register_0;
                        src1_q   <= bus.source_register_1;
                        imm_q    <= bus.immediate;
                    end
                end
                S_OPERAND: begin
                    op_a_q    <= bus.read_data_port_0;
                    op_b_q    <= bus.read_data_port_1;
                    acc_q     <= '0;
                    mul_cnt_q <= '0;
                end
                S_EXECUTE: begin
                    if (opcode_q == OP_MUL) begin
                        acc_q     <= mul_acc_next;
                        op_a_q    <= op_a_q << 1;
                        op_b_q    <= op_b_q >> 1;
                        mul_cnt_q <= mul_cnt_q + 5'd1;
                        if (exec_done) begin
                            wr_reg_q  <= dest_q;
                            wr_data_q <= mul_acc_next;
                        end
                    end else begin
                        wr_reg_q  <= dest_q;
                        wr_data_q <= alu_result;
                    end
                end
                S_WRITE: begin
                    zero_q    <= (wr_data_q == '0);
                    retired_q <= retired_q + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_register_file_controller.sv
`timescale 1ns/1ps
module tb_register_file_controller;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    register_file_controller_if bus();

    register_file_controller dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Register file the controller drives.
    logic [31:0] rf [4] = '{32'd0, 32'd0, 32'd0, 32'd0};
    assign bus.read_data_port_0 = rf[bus.read_register_port_0];
    assign bus.read_data_port_1 = rf[bus.read_register_port_1];
    always @(posedge clk) if (bus.write_enable === 1'b1) rf[bus.write_register] <= bus.write_data;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    logic [31:0] ref_rf [4] = '{32'd0, 32'd0, 32'd0, 32'd0};
    logic        exp_zero    = 1'b0;
    logic [15:0] exp_retired = 16'd0;
    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [15:0] imm);
        logic [63:0] p;
        case (op)
            3'b000: return a + b;
            3'b001: return a - b;
            3'b010: return a & b;
            3'b011: return a | b;
            3'b100: return a ^ b;
            3'b101: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b110: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            default: return {16'd0, imm};
        endcase
    endfunction

    task automatic push_expect(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs0,
                               input logic [1:0] rs1, input logic [15:0] imm, input int t);
        exp_t e;
        logic [31:0] r;
        r = model(op, ref_rf[rs0], ref_rf[rs1], imm);
        ref_rf[rd]  = r;
        exp_zero    = (r == 32'd0);
        exp_retired = exp_retired + 16'd1;
        e.rd   = rd;
        e.data = r;
        e.cyc  = t + ((op == 3'b110) ? 35 : 4);
        sb.push_back(e);
    endtask

    // Scoreboard consumer: every strobe must match the oldest expectation,
    // in the expected cycle, with address/data stable one cycle either side.
    exp_t        mon_e;
    logic [1:0]  prev_wr = '0;
    logic [31:0] prev_wd = '0;
    bit          hold_chk = 0;
    logic [1:0]  hold_wr;
    logic [31:0] hold_wd;
    always @(negedge clk) begin
        if (hold_chk) begin
            hold_chk = 0;
            n_cmp++;
            if (bus.write_register !== hold_wr || bus.write_data !== hold_wd || bus.write_enable !== 1'b0) begin
                n_err++;
                $display("FAIL hold: got rd=%0d data=%h we=%b, want rd=%0d data=%h we=0",
                         bus.write_register, bus.write_data, bus.write_enable, hold_wr, hold_wd);
            end
        end
        if (bus.write_enable !== 1'b0) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_strobe: got we=%b rd=%0d data=%h at cyc %0d, want no strobe",
                         bus.write_enable, bus.write_register, bus.write_data, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (bus.write_register !== mon_e.rd || bus.write_data !== mon_e.data || cyc != mon_e.cyc) begin
                    n_err++;
                    $display("FAIL write: got rd=%0d data=%h cyc=%0d, want rd=%0d data=%h cyc=%0d",
                             bus.write_register, bus.write_data, cyc, mon_e.rd, mon_e.data, mon_e.cyc);
                end
                n_cmp++;
                if (prev_wr !== bus.write_register || prev_wd !== bus.write_data) begin
                    n_err++;
                    $display("FAIL setup: got rd=%0d data=%h, want rd=%0d data=%h",
                             prev_wr, prev_wd, bus.write_register, bus.write_data);
                end
                hold_chk = 1;
                hold_wr  = bus.write_register;
                hold_wd  = bus.write_data;
            end
        end
        prev_wr = bus.write_register;
        prev_wd = bus.write_data;
    end

    task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs0,
                         input logic [1:0] rs1, input logic [15:0] imm, output int acc_cyc);
        int w = 0;
        @(posedge clk); #1;
        bus.instruction_valid    = 1'b1;
        bus.opcode               = op;
        bus.destination_register = rd;
        bus.source_register_0    = rs0;
        bus.source_register_1    = rs1;
        bus.immediate            = imm;
        @(negedge clk);
        while (bus.instruction_ready !== 1'b1 && w < 100) begin @(negedge clk); w++; end
        n_cmp++;
        if (w >= 100) begin
            n_err++;
            $display("FAIL accept_timeout: got ready=%b, want 1 within 100 cycles", bus.instruction_ready);
            acc_cyc = -1;
        end else begin
            acc_cyc = cyc;
            push_expect(op, rd, rs0, rs1, imm, cyc);
        end
        @(posedge clk); #1;
        bus.instruction_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int w = 0;
        @(negedge clk);
        while ((sb.size() != 0 || bus.instruction_ready !== 1'b1) && w < 100) begin @(negedge clk); w++; end
        n_cmp++;
        if (w >= 100) begin
            n_err++;
            $display("FAIL %s_drain: got pending=%0d ready=%b, want 0 and 1", tag, sb.size(), bus.instruction_ready);
        end
    endtask

    task automatic check_status(input string tag);
        n_cmp++;
        if (bus.zero_flag !== exp_zero || bus.retired_count !== exp_retired) begin
            n_err++;
            $display("FAIL %s_status: got zero=%b retired=%0d, want zero=%b retired=%0d",
                     tag, bus.zero_flag, bus.retired_count, exp_zero, exp_retired);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.write_enable !== 1'b0 || bus.write_register !== 2'd0 || bus.write_data !== 32'd0 ||
            bus.read_register_port_0 !== 2'd0 || bus.read_register_port_1 !== 2'd0 ||
            bus.zero_flag !== 1'b0 || bus.retired_count !== 16'd0 || bus.instruction_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_values: got we=%b wr=%0d wd=%h rp0=%0d rp1=%0d z=%b rc=%0d rdy=%b, want all 0",
                     bus.write_enable, bus.write_register, bus.write_data, bus.read_register_port_0,
                     bus.read_register_port_1, bus.zero_flag, bus.retired_count, bus.instruction_ready);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.instruction_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_after_reset: got %b, want 1", bus.instruction_ready);
        end
    endtask

    task automatic test_ldi();
        int t;
        issue(3'b111, 2'd1, 2'd0, 2'd0, 16'h1234, t);
        drain("ldi");
        check_status("ldi");
        n_cmp++;
        if (rf[1] !== 32'h0000_1234 || bus.retired_count !== 16'd1) begin
            n_err++;
            $display("FAIL ldi_r1: got r1=%h retired=%0d, want 00001234 and 1", rf[1], bus.retired_count);
        end
    endtask

    task automatic test_sub_add_wrap();
        int t;
        issue(3'b111, 2'd0, 2'd0, 2'd0, 16'h0000, t);
        issue(3'b111, 2'd1, 2'd0, 2'd0, 16'h0001, t);
        issue(3'b001, 2'd3, 2'd0, 2'd1, 16'h0000, t);
        drain("sub");
        check_status("sub");
        n_cmp++;
        if (rf[3] !== 32'hFFFF_FFFF || bus.zero_flag !== 1'b0) begin
            n_err++;
            $display("FAIL sub_wrap: got r3=%h z=%b, want ffffffff and 0", rf[3], bus.zero_flag);
        end
        issue(3'b000, 2'd2, 2'd3, 2'd1, 16'h0000, t);
        drain("add");
        check_status("add");
        n_cmp++;
        if (rf[2] !== 32'd0 || bus.zero_flag !== 1'b1) begin
            n_err++;
            $display("FAIL add_wrap: got r2=%h z=%b, want 00000000 and 1", rf[2], bus.zero_flag);
        end
    endtask

    task automatic test_mul();
        int t;
        int busy_bad = 0;
        issue(3'b111, 2'd1, 2'd0, 2'd0, 16'h1234, t);
        issue(3'b111, 2'd2, 2'd0, 2'd0, 16'hFFFF, t);
        drain("mul_setup");
        issue(3'b110, 2'd3, 2'd1, 2'd2, 16'h0000, t);
        for (int i = 1; i <= 36; i++) begin
            @(negedge clk);
            if (bus.instruction_ready !== 1'b0) busy_bad++;
        end
        n_cmp++;
        if (busy_bad != 0) begin
            n_err++;
            $display("FAIL mul_busy: got ready high in %0d of 36 busy cycles, want 0", busy_bad);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.instruction_ready !== 1'b1 || cyc != t + 37) begin
            n_err++;
            $display("FAIL mul_idle: got ready=%b at cyc %0d, want 1 at cyc %0d", bus.instruction_ready, cyc, t + 37);
        end
        check_status("mul");
        n_cmp++;
        if (rf[3] !== 32'h1233_EDCC) begin
            n_err++;
            $display("FAIL mul_result: got %h, want 1233edcc", rf[3]);
        end
    endtask

    task automatic test_slt();
        int t;
        issue(3'b111, 2'd0, 2'd0, 2'd0, 16'h0000, t);
        issue(3'b111, 2'd1, 2'd0, 2'd0, 16'h0001, t);
        issue(3'b001, 2'd3, 2'd0, 2'd1, 16'h0000, t);
        issue(3'b101, 2'd0, 2'd3, 2'd1, 16'h0000, t);
        drain("slt_a");
        n_cmp++;
        if (rf[0] !== 32'd1) begin
            n_err++;
            $display("FAIL slt_neg_lt_pos: got %h, want 00000001", rf[0]);
        end
        issue(3'b101, 2'd0, 2'd1, 2'd3, 16'h0000, t);
        drain("slt_b");
        check_status("slt");
        n_cmp++;
        if (rf[0] !== 32'd0) begin
            n_err++;
            $display("FAIL slt_pos_lt_neg: got %h, want 00000000", rf[0]);
        end
    endtask

    task automatic test_back_to_back();
        int t;
        int last = -1;
        int accepts = 0;
        logic [2:0] op;
        issue(3'b111, 2'd1, 2'd0, 2'd0, 16'h0005, t);
        issue(3'b000, 2'd1, 2'd1, 2'd1, 16'h0000, t);
        drain("self_add");
        n_cmp++;
        if (rf[1] !== 32'd10) begin
            n_err++;
            $display("FAIL self_add: got %h, want 0000000a", rf[1]);
        end
        // Valid held high, fields changing every cycle.
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            op = 3'($urandom_range(0, 6));
            if (op == 3'b110) op = 3'b111;
            bus.instruction_valid    = 1'b1;
            bus.opcode               = op;
            bus.destination_register = 2'($urandom_range(0, 3));
            bus.source_register_0    = 2'($urandom_range(0, 3));
            bus.source_register_1    = 2'($urandom_range(0, 3));
            bus.immediate            = 16'($urandom);
            @(negedge clk);
            if (bus.instruction_ready === 1'b1) begin
                push_expect(bus.opcode, bus.destination_register, bus.source_register_0,
                            bus.source_register_1, bus.immediate, cyc);
                accepts++;
                if (last >= 0) begin
                    n_cmp++;
                    if (cyc - last != 6) begin
                        n_err++;
                        $display("FAIL issue_spacing: got %0d cycles, want 6", cyc - last);
                    end
                end
                last = cyc;
            end
        end
        @(posedge clk); #1;
        bus.instruction_valid = 1'b0;
        drain("b2b");
        check_status("b2b");
        n_cmp++;
        if (accepts < 6) begin
            n_err++;
            $display("FAIL b2b_accepts: got %0d accepts, want at least 6", accepts);
        end
        for (int r = 0; r < 4; r++) begin
            n_cmp++;
            if (rf[r] !== ref_rf[r]) begin
                n_err++;
                $display("FAIL b2b_r%0d: got %h, want %h", r, rf[r], ref_rf[r]);
            end
        end
    endtask

    task automatic test_reset_mid_mul();
        int t;
        logic [31:0] saved [4];
        for (int r = 0; r < 4; r++) saved[r] = ref_rf[r];
        issue(3'b110, 2'd3, 2'd1, 2'd2, 16'h0000, t);
        while (cyc < t + 11) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.write_enable !== 1'b0 || bus.instruction_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: got we=%b ready=%b, want 0 and 0", bus.write_enable, bus.instruction_ready);
        end
        sb.delete();
        for (int r = 0; r < 4; r++) ref_rf[r] = saved[r];
        exp_zero    = 1'b0;
        exp_retired = 16'd0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.instruction_ready !== 1'b1 || bus.write_enable !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got ready=%b we=%b, want 1 and 0", bus.instruction_ready, bus.write_enable);
        end
        check_status("reset_mid");
        issue(3'b111, 2'd2, 2'd0, 2'd0, 16'h00AB, t);
        drain("post_reset");
        check_status("post_reset");
        for (int r = 0; r < 4; r++) begin
            n_cmp++;
            if (rf[r] !== ref_rf[r]) begin
                n_err++;
                $display("FAIL post_reset_r%0d: got %h, want %h", r, rf[r], ref_rf[r]);
            end
        end
    endtask

    initial begin
        bus.instruction_valid    = 1'b0;
        bus.opcode               = 3'd0;
        bus.destination_register = 2'd0;
        bus.source_register_0    = 2'd0;
        bus.source_register_1    = 2'd0;
        bus.immediate            = 16'd0;
        test_reset();
        test_ldi();
        test_sub_add_wrap();
        test_mul();
        test_slt();
        test_back_to_back();
        test_reset_mid_mul();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000 ns, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
